// File: rtl/jam_pkg.sv
// Shared constants, state encoding and the permutation slice helper for the
// jam_cost_eval slice.
package jam_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned COST_W = 7;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned CNT_W  = 4;

  localparam logic [SUM_W-1:0] MIN_INIT = 10'h3FF;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } jam_state_e;

  // Job index assigned to worker k: bits 3k+2:3k of the packed permutation.
  function automatic logic [IDX_W-1:0] perm_slice(input logic [N*IDX_W-1:0] p,
                                                  input logic [IDX_W-1:0]   k);
    return p[IDX_W*k +: IDX_W];
  endfunction

endpackage

// File: rtl/jam_best_tracker.sv
// Best-cost tracker: running minimum, match count and run-start flag, plus the
// result snapshot presented on MinCost/MatchCount.
module jam_best_tracker
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmp_en,
  input  logic             snap_en,
  input  logic             done_en,
  input  logic [SUM_W-1:0] acc,
  output logic [SUM_W-1:0] min_val,
  output logic             first,
  output logic [SUM_W-1:0] MinCost,
  output logic [CNT_W-1:0] MatchCount
);

  logic [SUM_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [SUM_W-1:0] min_cost_q;
  logic [CNT_W-1:0] match_q;

  // Compare-and-update of the running best, with saturating match count.
  always_comb begin
    min_d   = min_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (cmp_en) begin
      if (first_q) begin
        min_d   = acc;
        cnt_d   = CNT_W'(1);
        first_d = 1'b0;
      end else if (acc < min_q) begin
        min_d = acc;
        cnt_d = CNT_W'(1);
      end else if ((acc == min_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Re-arm for the next run once the result has been presented.
    if (done_en) begin
      first_d = 1'b1;
    end
  end

  // Tracker state registers.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      min_q   <= MIN_INIT;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Result snapshot, loaded on the edge entering DONE so the values are
  // already valid while the Valid pulse is high; it includes the final compare.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      min_cost_q <= '0;
      match_q    <= '0;
    end else if (snap_en) begin
      min_cost_q <= min_d;
      match_q    <= cnt_d;
    end
  end

  assign min_val    = min_q;
  assign first      = first_q;
  assign MinCost    = min_cost_q;
  assign MatchCount = match_q;

endmodule

// File: rtl/jam_cost_eval.sv
// Cost evaluator: fetches the 8 costs of one worker->job assignment, sums them
// and feeds the best-cost tracker. All state updates on the falling CLK edge.
// Optional build macro JAM_EVAL_PRUNE_EN abandons a permutation as soon as its
// partial sum exceeds the current minimum (results unchanged, latency shorter).
module jam_cost_eval
  import jam_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [N*IDX_W-1:0] perm,
  input  logic               perm_last,
  input  logic               perm_valid,
  output logic               perm_ready,
  output logic [IDX_W-1:0]   W,
  output logic [IDX_W-1:0]   J,
  input  logic [COST_W-1:0]  Cost,
  output logic [SUM_W-1:0]   MinCost,
  output logic [CNT_W-1:0]   MatchCount,
  output logic               Valid
);

  jam_state_e         state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [N*IDX_W-1:0] perm_q, perm_d;
  logic               last_q, last_d;

  logic [SUM_W-1:0]   acc_sum;
  logic [SUM_W-1:0]   min_val;
  logic               first;
  logic               prune_en;
  logic               prune_cand;
  logic               prune;

  // Cost arrives one cycle after its W/J read; no overflow is possible at SUM_W.
  assign acc_sum = acc_q + {{(SUM_W-COST_W){1'b0}}, Cost};

`ifdef JAM_EVAL_PRUNE_EN
  assign prune_en = 1'b1;
`else
  assign prune_en = 1'b0;
`endif

  // Strict '>' keeps equal-cost permutations alive so they are still counted.
  assign prune_cand = !first && (acc_sum > min_val);

  // FSM next state, fetch counter and accumulator.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    perm_d  = perm_q;
    last_d  = last_q;
    prune   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (perm_valid) begin
          perm_d  = perm;
          last_d  = perm_last;
          acc_d   = '0;
          k_d     = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        k_d = k_q + IDX_W'(1);
        // The first FETCH cycle has no returning cost yet.
        if (k_q != '0) begin
          acc_d = acc_sum;
          prune = prune_en && prune_cand;
        end
        if (prune) begin
          state_d = last_q ? DONE : IDLE;
        end else if (k_q == IDX_W'(N-1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_d = acc_sum;
        prune = prune_en && prune_cand;
        if (prune) begin
          state_d = last_q ? DONE : IDLE;
        end else begin
          state_d = CMP;
        end
      end
      CMP: begin
        state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset aborts any evaluation in flight.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      perm_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      perm_q  <= perm_d;
      last_q  <= last_d;
    end
  end

  jam_best_tracker u_tracker (
    .CLK        (CLK),
    .RST        (RST),
    .cmp_en     (state_q == CMP),
    .snap_en    ((state_d == DONE) && (state_q != DONE)),
    .done_en    (state_q == DONE),
    .acc        (acc_q),
    .min_val    (min_val),
    .first      (first),
    .MinCost    (MinCost),
    .MatchCount (MatchCount)
  );

  assign perm_ready = (state_q == IDLE);
  assign W          = (state_q == FETCH) ? k_q : '0;
  assign J          = (state_q == FETCH) ? perm_slice(perm_q, k_q) : '0;
  assign Valid      = (state_q == DONE);

endmodule

// File: tb/tb_jam_cost_eval.sv
// Scoreboard bench for jam_cost_eval: directed permutations are issued, the
// expected result of each run is queued, and a monitor checks every Valid.
`timescale 1ns/1ps
module tb_jam_cost_eval;
  import jam_pkg::*;

  logic               CLK;
  logic               RST;
  logic [N*IDX_W-1:0] perm;
  logic               perm_last;
  logic               perm_valid;
  logic               perm_ready;
  logic [IDX_W-1:0]   W;
  logic [IDX_W-1:0]   J;
  logic [COST_W-1:0]  Cost;
  logic [SUM_W-1:0]   MinCost;
  logic [CNT_W-1:0]   MatchCount;
  logic               Valid;

  typedef struct {
    int min_cost;
    int match_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;
  int   lat;

  logic [COST_W-1:0] cost_tbl [N][N];

  jam_cost_eval dut (
    .CLK        (CLK),
    .RST        (RST),
    .perm       (perm),
    .perm_last  (perm_last),
    .perm_valid (perm_valid),
    .perm_ready (perm_ready),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered cost source: data follows W/J by one clock.
  initial Cost = '0;
  always @(negedge CLK) Cost <= cost_tbl[W][J];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every Valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      if (RST && Valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", int'(Valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("min_cost", int'(MinCost), e.min_cost);
          check("match_count", int'(MatchCount), e.match_cnt);
        end
      end
    end
  end

  function automatic logic [N*IDX_W-1:0] mk_swap(input int a);
    logic [N*IDX_W-1:0] p;
    for (int k = 0; k < N; k++) p[IDX_W*k +: IDX_W] = IDX_W'(k);
    p[IDX_W*0 +: IDX_W] = IDX_W'(a);
    p[IDX_W*a +: IDX_W] = '0;
    return p;
  endfunction

  task automatic fill(input int v);
    for (int w = 0; w < N; w++)
      for (int j = 0; j < N; j++) cost_tbl[w][j] = COST_W'(v);
  endtask

  task automatic push_exp(input int m, input int c);
    exp_t e;
    e.min_cost  = m;
    e.match_cnt = c;
    exp_q.push_back(e);
  endtask

  // Handshake one permutation; returns just after the accepting edge.
  task automatic send(input logic [N*IDX_W-1:0] p, input logic last);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      if (perm_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("handshake_timeout", int'(perm_ready), 1);
    end else begin
      perm       = p;
      perm_last  = last;
      perm_valid = 1'b1;
      @(negedge CLK);
      #1 perm_valid = 1'b0;
    end
  endtask

  // Falling edges after the accepting edge until perm_ready returns.
  task automatic measure(output int cycles);
    cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      if (perm_ready) break;
      @(negedge CLK);
      cycles++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      if (exp_q.size() == 0 && perm_ready) break;
    end
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    RST        = 1'b0;
    perm       = '0;
    perm_last  = 1'b0;
    perm_valid = 1'b0;
    fill(0);
    repeat (2) @(negedge CLK);
    #1;
    check("rst_W", int'(W), 0);
    check("rst_J", int'(J), 0);
    check("rst_MinCost", int'(MinCost), 0);
    check("rst_MatchCount", int'(MatchCount), 0);
    check("rst_Valid", int'(Valid), 0);
    check("rst_perm_ready", int'(perm_ready), 1);
    RST = 1'b1;

    // All costs 1, three permutations: 8 each.
    fill(1);
    send(mk_swap(0), 1'b0);
    measure(lat);
    check("lat_nonlast", lat, 10);
    send(mk_swap(2), 1'b0);
    push_exp(8, 3);
    send(mk_swap(4), 1'b1);
    measure(lat);
    check("lat_last", lat, 11);
    drain();
    repeat (3) @(posedge CLK);
    check("min_hold", int'(MinCost), 8);

    // Diagonal zero, others 10: identity 0, swap(0,1) 20.
    fill(10);
    for (int i = 0; i < N; i++) cost_tbl[i][i] = '0;
    send(mk_swap(0), 1'b0);
    push_exp(0, 1);
    send(mk_swap(1), 1'b1);
    drain();

    // Worker 0 costs 5j, others 5: sums 50, 40, 40, 60.
    fill(5);
    for (int j = 0; j < N; j++) cost_tbl[0][j] = COST_W'(5 * j);
    send(mk_swap(3), 1'b0);
    send(mk_swap(1), 1'b0);
    send(mk_swap(1), 1'b0);
    push_exp(40, 2);
    send(mk_swap(5), 1'b1);
    drain();

    // 20 permutations of sum 16: count saturates.
    fill(2);
    for (int i = 0; i < 19; i++) send(mk_swap(i % N), 1'b0);
    push_exp(16, 15);
    send(mk_swap(7), 1'b1);
    drain();

    // Reset during the 5th FETCH, then a fresh run with sums 30, 25.
    fill(1);
    send(mk_swap(0), 1'b0);
    repeat (4) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    check("midrst_perm_ready", int'(perm_ready), 1);
    check("midrst_Valid", int'(Valid), 0);
    check("midrst_MinCost", int'(MinCost), 0);
    @(negedge CLK);
    #1 RST = 1'b1;
    cost_tbl[0][2] = COST_W'(23);
    cost_tbl[0][3] = COST_W'(18);
    send(mk_swap(2), 1'b0);
    push_exp(25, 1);
    send(mk_swap(3), 1'b1);
    drain();

    // Sum 8, then a costly worker 0 (prunable), then sum 8 again.
    fill(1);
    cost_tbl[0][0] = COST_W'(100);
    send(mk_swap(1), 1'b0);
    send(mk_swap(0), 1'b0);
    measure(lat);
`ifdef JAM_EVAL_PRUNE_EN
    check("lat_pruned", lat, 2);
`else
    check("lat_pruned", lat, 10);
`endif
    push_exp(8, 2);
    send(mk_swap(1), 1'b1);
    measure(lat);
    check("lat_last_after_prune", lat, 11);
    drain();

    repeat (3) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
